// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   Runs the interrupt entry sequence: pushes PCH, PCL and P onto the page-1
//   stack, fetches the NMI or IRQ vector, then pulses done with the loaded
//   vector and final stack pointer.
//
// Configuration macro:
//   INT_SEQ_NMI_HIJACK_EN - when defined, an IRQ sequence that sees a pending
//   NMI on entry to FETCH_LO fetches the NMI vector instead (pushes unchanged).
//
// Ports:
//   clk_i            clock, all state changes on rising edge
//   reset_i          synchronous active-high reset
//   take_irq_i       level IRQ request (already masked upstream)
//   take_nmi_i       one-cycle NMI edge pulse
//   insn_boundary_i  core may start a new instruction this cycle
//   pc_in_i          return address to push
//   p_in_i           status register to push
//   sp_in_i          stack pointer at sequence start
//   din_i            read data, valid the cycle after addr_o is driven
//   addr_o           bus address
//   we_o             write strobe
//   dout_o           write data
//   busy_o           sequence in progress (core stalls)
//   done_o           one-cycle completion pulse
//   pc_out_o         loaded vector
//   sp_out_o         final stack pointer
//   set_i_o          set I flag (with done_o)
//
// State table:
//   S_IDLE     | waiting for an instruction boundary with a request
//   S_PUSH_PCH | write pc[15:8] to {01,sp}, sp--
//   S_PUSH_PCL | write pc[7:0]  to {01,sp}, sp--
//   S_PUSH_P   | write status (B=0, bit5=1) to {01,sp}, sp--
//   S_FETCH_LO | drive vector address
//   S_FETCH_HI | drive vector+1, capture low byte
//   S_DONE     | capture high byte, pulse done/set_i
module interrupt_sequencer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        take_irq_i,
  input  logic        take_nmi_i,
  input  logic        insn_boundary_i,
  input  logic [15:0] pc_in_i,
  input  logic [7:0]  p_in_i,
  input  logic [7:0]  sp_in_i,
  input  logic [7:0]  din_i,
  output logic [15:0] addr_o,
  output logic        we_o,
  output logic [7:0]  dout_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] pc_out_o,
  output logic [7:0]  sp_out_o,
  output logic        set_i_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_FETCH_LO,
    S_FETCH_HI,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        kind_nmi_q, kind_nmi_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  pc_lo_q, pc_lo_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [7:0]  sp_out_q, sp_out_d;
  logic [15:0] vec;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      nmi_pend_q <= 1'b0;
      kind_nmi_q <= 1'b0;
      pc_q       <= 16'h0000;
      p_q        <= 8'h00;
      sp_q       <= 8'h00;
      pc_lo_q    <= 8'h00;
      pc_out_q   <= 16'h0000;
      sp_out_q   <= 8'hFF;
    end else begin
      state_q    <= state_d;
      nmi_pend_q <= nmi_pend_d;
      kind_nmi_q <= kind_nmi_d;
      pc_q       <= pc_d;
      p_q        <= p_d;
      sp_q       <= sp_d;
      pc_lo_q    <= pc_lo_d;
      pc_out_q   <= pc_out_d;
      sp_out_q   <= sp_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nmi_pend_d = nmi_pend_q;
    kind_nmi_d = kind_nmi_q;
    pc_d       = pc_q;
    p_d        = p_q;
    sp_d       = sp_q;
    pc_lo_d    = pc_lo_q;
    pc_out_d   = pc_out_q;
    sp_out_d   = sp_out_q;
    addr_o     = 16'h0000;
    we_o       = 1'b0;
    dout_o     = 8'h00;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    set_i_o    = 1'b0;
    pc_out_o   = pc_out_q;
    sp_out_o   = sp_out_q;
    vec        = kind_nmi_q ? 16'hFFFA : 16'hFFFE;

    // An NMI edge is never lost; later branches may consume it.
    if (take_nmi_i) nmi_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (insn_boundary_i && (nmi_pend_q || take_nmi_i || take_irq_i)) begin
          state_d = S_PUSH_PCH;
          pc_d    = pc_in_i;
          p_d     = p_in_i;
          sp_d    = sp_in_i;
          if (nmi_pend_q || take_nmi_i) begin
            kind_nmi_d = 1'b1;
            nmi_pend_d = 1'b0;
          end else begin
            kind_nmi_d = 1'b0;
          end
        end
      end
      S_PUSH_PCH: begin
        addr_o  = {8'h01, sp_q};
        dout_o  = pc_q[15:8];
        we_o    = 1'b1;
        sp_d    = sp_q - 8'd1;
        state_d = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        addr_o  = {8'h01, sp_q};
        dout_o  = pc_q[7:0];
        we_o    = 1'b1;
        sp_d    = sp_q - 8'd1;
        state_d = S_PUSH_P;
      end
      S_PUSH_P: begin
        addr_o  = {8'h01, sp_q};
        dout_o  = (p_q & 8'hEF) | 8'h20;
        we_o    = 1'b1;
        sp_d    = sp_q - 8'd1;
        state_d = S_FETCH_LO;
`ifdef INT_SEQ_NMI_HIJACK_EN
        // Decided on the edge into FETCH_LO, so an NMI pulse arriving in
        // this cycle already counts as pending.
        if (!kind_nmi_q && (nmi_pend_q || take_nmi_i)) begin
          kind_nmi_d = 1'b1;
          nmi_pend_d = 1'b0;
        end
`endif
      end
      S_FETCH_LO: begin
        addr_o  = vec;
        state_d = S_FETCH_HI;
      end
      S_FETCH_HI: begin
        addr_o  = vec + 16'd1;
        pc_lo_d = din_i;
        state_d = S_DONE;
      end
      S_DONE: begin
        // High byte arrives this cycle, so the outputs bypass the holding
        // registers to be valid alongside done.
        done_o   = 1'b1;
        set_i_o  = 1'b1;
        pc_out_o = {din_i, pc_lo_q};
        sp_out_o = sp_q;
        pc_out_d = {din_i, pc_lo_q};
        sp_out_d = sp_q;
        state_d  = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset, take_irq, take_nmi, insn_boundary;
  logic [15:0] pc_in;
  logic [7:0]  p_in, sp_in, din;
  logic [15:0] addr, pc_out;
  logic        we, busy, done, set_i;
  logic [7:0]  dout, sp_out;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int lat;
  int cnt0;
  logic idle_ok;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];

  // vector bytes FFFA..FFFF indexed by addr[2:0]
  logic [7:0]  vec_mem [0:7];
  logic [15:0] rd_addr = 16'h0000;

  interrupt_sequencer dut (
    .clk_i(clk), .reset_i(reset), .take_irq_i(take_irq), .take_nmi_i(take_nmi),
    .insn_boundary_i(insn_boundary), .pc_in_i(pc_in), .p_in_i(p_in), .sp_in_i(sp_in),
    .din_i(din), .addr_o(addr), .we_o(we), .dout_o(dout), .busy_o(busy),
    .done_o(done), .pc_out_o(pc_out), .sp_out_o(sp_out), .set_i_o(set_i)
  );

  always #5 clk = ~clk;

  // registered-read memory: data for an address appears the following cycle
  always @(posedge clk) rd_addr <= addr;
  assign din = (rd_addr[15:3] == 13'h1FFF && rd_addr[2:0] >= 3'd2) ? vec_mem[rd_addr[2:0]] : 8'h00;

  always @(negedge clk) begin
    if (we) begin
      wa.push_back(addr);
      wd.push_back(dout);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input int i, input logic [15:0] ea, input logic [7:0] ed);
    if (i < wa.size()) begin
      chk($sformatf("wr%0d_addr", i), {16'h0, wa[i]}, {16'h0, ea});
      chk($sformatf("wr%0d_data", i), {24'h0, wd[i]}, {24'h0, ed});
    end else begin
      chk($sformatf("wr%0d_missing", i), wa.size(), i + 1);
    end
  endtask

  task automatic do_seq(input logic irq, input logic nmi, input logic keep_irq,
                        input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                        output int l);
    take_irq = irq; take_nmi = nmi; insn_boundary = 1'b1;
    pc_in = pc; p_in = p; sp_in = sp;
    wa.delete(); wd.delete();
    tick();
    take_nmi = 1'b0; insn_boundary = 1'b0; take_irq = keep_irq;
    chk("busy_rise", {31'h0, busy}, 32'h1);
    l = 1;
    while (!done && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vec_mem[i] = 8'h00;
    vec_mem[2] = 8'h00; vec_mem[3] = 8'h90;   // NMI -> 9000
    vec_mem[6] = 8'h00; vec_mem[7] = 8'h80;   // IRQ -> 8000
    reset = 1'b1; take_irq = 1'b0; take_nmi = 1'b0; insn_boundary = 1'b0;
    pc_in = 16'h0; p_in = 8'h0; sp_in = 8'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy",   {31'h0, busy},   32'h0);
    chk("rst_we",     {31'h0, we},     32'h0);
    chk("rst_addr",   {16'h0, addr},   32'h0);
    chk("rst_dout",   {24'h0, dout},   32'h0);
    chk("rst_done",   {31'h0, done},   32'h0);
    chk("rst_seti",   {31'h0, set_i},  32'h0);
    chk("rst_pcout",  {16'h0, pc_out}, 32'h0);
    chk("rst_spout",  {24'h0, sp_out}, 32'hFF);

    // basic IRQ, take_irq dropped right after start
    do_seq(1'b1, 1'b0, 1'b0, 16'h1234, 8'h30, 8'hFD, lat);
    chk("irq_lat",   lat, 6);
    chk("irq_pc",    {16'h0, pc_out}, 32'h8000);
    chk("irq_sp",    {24'h0, sp_out}, 32'hFA);
    chk("irq_seti",  {31'h0, set_i},  32'h1);
    chk("irq_nwr",   wa.size(), 3);
    chk_wr(0, 16'h01FD, 8'h12);
    chk_wr(1, 16'h01FC, 8'h34);
    chk_wr(2, 16'h01FB, 8'h20);
    tick();
    chk("idle_busy", {31'h0, busy},   32'h0);
    chk("idle_done", {31'h0, done},   32'h0);
    chk("idle_we",   {31'h0, we},     32'h0);
    chk("hold_pc",   {16'h0, pc_out}, 32'h8000);
    chk("hold_sp",   {24'h0, sp_out}, 32'hFA);

    // IRQ and NMI together: NMI first, IRQ afterwards
    do_seq(1'b1, 1'b1, 1'b1, 16'h4321, 8'hFF, 8'hFF, lat);
    chk("both_lat",  lat, 6);
    chk("both_pc",   {16'h0, pc_out}, 32'h9000);
    chk("both_sp",   {24'h0, sp_out}, 32'hFC);
    chk_wr(0, 16'h01FF, 8'h43);
    chk_wr(1, 16'h01FE, 8'h21);
    chk_wr(2, 16'h01FD, 8'hEF);
    tick();
    chk("both_idle", {31'h0, busy}, 32'h0);
    do_seq(1'b1, 1'b0, 1'b0, 16'h5678, 8'h00, 8'h40, lat);
    chk("after_lat", lat, 6);
    chk("after_pc",  {16'h0, pc_out}, 32'h8000);
    chk("after_sp",  {24'h0, sp_out}, 32'h3D);
    tick();

    // stack pointer wrap
    do_seq(1'b1, 1'b0, 1'b0, 16'hABCD, 8'hC4, 8'h01, lat);
    chk("wrap_lat",  lat, 6);
    chk_wr(0, 16'h0101, 8'hAB);
    chk_wr(1, 16'h0100, 8'hCD);
    chk_wr(2, 16'h01FF, 8'hE4);
    chk("wrap_sp",   {24'h0, sp_out}, 32'hFE);
    tick();

    // NMI away from a boundary is held pending
    take_nmi = 1'b1;
    tick();
    take_nmi = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (busy) idle_ok = 1'b0;
      tick();
    end
    chk("pend_wait", {31'h0, idle_ok}, 32'h1);
    do_seq(1'b0, 1'b0, 1'b0, 16'h2222, 8'h00, 8'hF0, lat);
    chk("pend_lat",  lat, 6);
    chk("pend_pc",   {16'h0, pc_out}, 32'h9000);
    tick();
    insn_boundary = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) idle_ok = 1'b0;
    end
    insn_boundary = 1'b0;
    chk("pend_clr",  {31'h0, idle_ok}, 32'h1);

    // reset in PUSH_PCL
    take_irq = 1'b1; insn_boundary = 1'b1; pc_in = 16'h7777; p_in = 8'h00; sp_in = 8'h80;
    wa.delete(); wd.delete();
    tick();
    take_irq = 1'b0; insn_boundary = 1'b0;
    tick();
    chk("pcl_we",    {31'h0, we},   32'h1);
    chk("pcl_addr",  {16'h0, addr}, 32'h017F);
    cnt0 = done_cnt;
    reset = 1'b1; take_nmi = 1'b1;
    tick();
    reset = 1'b0; take_nmi = 1'b0;
    chk("abort_we",   {31'h0, we},     32'h0);
    chk("abort_busy", {31'h0, busy},   32'h0);
    chk("abort_pc",   {16'h0, pc_out}, 32'h0);
    chk("abort_sp",   {24'h0, sp_out}, 32'hFF);
    insn_boundary = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy) idle_ok = 1'b0;
    end
    insn_boundary = 1'b0;
    chk("abort_nonmi", {31'h0, idle_ok}, 32'h1);
    chk("abort_done",  done_cnt, cnt0);
    chk("abort_nwr",   wa.size(), 2);

    // NMI pulse during IRQ PUSH_P
    take_irq = 1'b1; insn_boundary = 1'b1; pc_in = 16'h1000; p_in = 8'h00; sp_in = 8'hE0;
    tick();
    take_irq = 1'b0; insn_boundary = 1'b0;
    lat = 1;
    tick(); lat++;
    tick(); lat++;
    take_nmi = 1'b1;
    tick(); lat++;
    take_nmi = 1'b0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("mid_lat", lat, 6);
`ifdef INT_SEQ_NMI_HIJACK_EN
    chk("mid_pc",  {16'h0, pc_out}, 32'h9000);
    tick();
    insn_boundary = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) idle_ok = 1'b0;
    end
    insn_boundary = 1'b0;
    chk("hijack_no2nd", {31'h0, idle_ok}, 32'h1);
`else
    chk("mid_pc",  {16'h0, pc_out}, 32'h8000);
    tick();
    do_seq(1'b0, 1'b0, 1'b0, 16'h2000, 8'h00, 8'hD0, lat);
    chk("follow_lat", lat, 6);
    chk("follow_pc",  {16'h0, pc_out}, 32'h9000);
    chk("follow_nwr", wa.size(), 3);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
